ball_controller: RTL and testbench



---
 rtl/ball_pkg.sv | 49 ++++
 rtl/step_divider.sv | 39 +++
 rtl/ball_controller.sv | 196 +++++++++++++++++++
 tb/tb_ball_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared geometry, state encoding and helpers for the paddle-game
// ball engine. All coordinates are 10-bit pixel positions on a 640x480 field.
package ball_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned BR       = 4;    // ball half-size

   localparam logic [9:0] LEFT_FACE_X  = 10'd28;
   localparam logic [9:0] RIGHT_FACE_X = 10'd611;

   // Ball-centre positions at which contact/miss/wall events happen
   localparam logic [9:0] LEFT_HIT_X   = LEFT_FACE_X + 10'(BR);
   localparam logic [9:0] RIGHT_HIT_X  = RIGHT_FACE_X - 10'(BR);
   localparam logic [9:0] LEFT_MISS_X  = 10'(BR);
   localparam logic [9:0] RIGHT_MISS_X = 10'(SCREEN_W - 1 - BR);
   localparam logic [9:0] TOP_Y        = 10'(BR);
   localparam logic [9:0] BOTTOM_Y     = 10'(SCREEN_H - 1 - BR);

   localparam logic [9:0] HALF_H_SMALL = 10'd40;
   localparam logic [9:0] HALF_H_LARGE = 10'd50;

   localparam logic [9:0] CENTRE_X = 10'd320;
   localparam logic [9:0] CENTRE_Y = 10'd240;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      SCORED,
      OVER
   } state_e;

   // |ball_y - paddle_y| <= half-height + BR, subtracting the smaller from
   // the larger so the difference never wraps.
   function automatic logic paddle_hit(input logic [9:0] by,
                                       input logic [9:0] py,
                                       input logic       small_bat);
      logic [9:0] diff;
      logic [9:0] reach;
      diff  = (by >= py) ? (by - py) : (py - by);
      reach = (small_bat ? HALF_H_SMALL : HALF_H_LARGE) + 10'(BR);
      return (diff <= reach);
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/step_divider.sv
// step_divider: free-running modulo-STEP_PERIOD counter producing the ball
// step tick.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  forces the count to 0 on the next edge
//   tick  out high in the cycle where count == STEP_PERIOD-1
module step_divider #(
   parameter int unsigned STEP_PERIOD = 131072
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned   CW   = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q + CW'(1);
      if (clear || (count_q == LAST)) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == LAST);

endmodule

// File: rtl/ball_controller.sv
// ball_controller: ball motion, wall/paddle reflection, miss detection and
// scoring for the two-player paddle game. All outputs are registered.
//   clk, rst            clock, synchronous active-high reset
//   p1_y, p2_y          left/right paddle centre Y
//   bat_size            1 = half-height 40, 0 = half-height 50
//   serve               starts play while idle
//   ball_x, ball_y      ball centre
//   p1_point, p2_point  one-cycle pulse when that player scores
//   p1_score, p2_score  saturating scores
//   in_play, game_over  state flags
module ball_controller
   import ball_pkg::*;
#(
   parameter int unsigned STEP_PERIOD = 131072,
   parameter int unsigned HOLD_STEPS  = 64,
   parameter int unsigned WIN_SCORE   = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] p1_y,
   input  logic [9:0] p2_y,
   input  logic       bat_size,
   input  logic       serve,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       p1_point,
   output logic       p2_point,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic       in_play,
   output logic       game_over
);

   localparam int unsigned   HW        = $clog2(HOLD_STEPS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
   localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

   state_e        state_q, state_d;
   logic [9:0]    ball_x_q, ball_x_d;
   logic [9:0]    ball_y_q, ball_y_d;
   logic          dx_q, dx_d;
   logic          dy_q, dy_d;
   logic          p1_point_q, p1_point_d;
   logic          p2_point_q, p2_point_d;
   logic [3:0]    p1_score_q, p1_score_d;
   logic [3:0]    p2_score_q, p2_score_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          in_play_q, in_play_d;
   logic          game_over_q, game_over_d;

   logic tick;
   logic div_clear;
   logic hit1;
   logic hit2;

   step_divider #(
      .STEP_PERIOD (STEP_PERIOD)
   ) u_step_divider (
      .clk   (clk),
      .rst   (rst),
      .clear (div_clear),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      p1_point_d = 1'b0;
      p2_point_d = 1'b0;
      p1_score_d = p1_score_q;
      p2_score_d = p2_score_q;
      hold_d     = hold_q;
      div_clear  = 1'b0;
      hit1       = paddle_hit(ball_y_q, p1_y, bat_size);
      hit2       = paddle_hit(ball_y_q, p2_y, bat_size);

      case (state_q)
         IDLE: begin
            ball_x_d  = CENTRE_X;
            ball_y_d  = CENTRE_Y;
            div_clear = 1'b1;
            if (serve) begin
               state_d = PLAY;
            end
         end

         PLAY: begin
            if (tick) begin
               if (!dx_q && (ball_x_q == LEFT_MISS_X)) begin
                  p2_point_d = 1'b1;
                  p2_score_d = sat_inc(p2_score_q);
                  dx_d       = 1'b0;
                  hold_d     = '0;
                  div_clear  = 1'b1;
                  state_d    = SCORED;
               end else if (dx_q && (ball_x_q == RIGHT_MISS_X)) begin
                  p1_point_d = 1'b1;
                  p1_score_d = sat_inc(p1_score_q);
                  dx_d       = 1'b1;
                  hold_d     = '0;
                  div_clear  = 1'b1;
                  state_d    = SCORED;
               end else begin
                  // Direction updates are resolved first so each axis moves
                  // in its new direction on the same tick; both axes may
                  // reflect together at a corner.
                  dy_d = dy_q;
                  if (!dy_q && (ball_y_q == TOP_Y)) begin
                     dy_d = 1'b1;
                  end else if (dy_q && (ball_y_q == BOTTOM_Y)) begin
                     dy_d = 1'b0;
                  end
                  ball_y_d = dy_d ? (ball_y_q + 10'd1) : (ball_y_q - 10'd1);

                  dx_d = dx_q;
                  if (!dx_q && (ball_x_q == LEFT_HIT_X) && hit1) begin
                     dx_d = 1'b1;
                  end else if (dx_q && (ball_x_q == RIGHT_HIT_X) && hit2) begin
                     dx_d = 1'b0;
                  end
                  ball_x_d = dx_d ? (ball_x_q + 10'd1) : (ball_x_q - 10'd1);
               end
            end
         end

         SCORED: begin
            if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  if ((p1_score_q == WIN) || (p2_score_q == WIN)) begin
                     state_d = OVER;
                  end else begin
                     state_d  = IDLE;
                     ball_x_d = CENTRE_X;
                     ball_y_d = CENTRE_Y;
                  end
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end

         OVER: begin
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      in_play_d   = (state_d == PLAY);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ball_x_q    <= CENTRE_X;
         ball_y_q    <= CENTRE_Y;
         dx_q        <= 1'b1;
         dy_q        <= 1'b1;
         p1_point_q  <= 1'b0;
         p2_point_q  <= 1'b0;
         p1_score_q  <= '0;
         p2_score_q  <= '0;
         hold_q      <= '0;
         in_play_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         p1_point_q  <= p1_point_d;
         p2_point_q  <= p2_point_d;
         p1_score_q  <= p1_score_d;
         p2_score_q  <= p2_score_d;
         hold_q      <= hold_d;
         in_play_q   <= in_play_d;
         game_over_q <= game_over_d;
      end
   end

   assign ball_x    = ball_x_q;
   assign ball_y    = ball_y_q;
   assign p1_point  = p1_point_q;
   assign p2_point  = p2_point_q;
   assign p1_score  = p1_score_q;
   assign p2_score  = p2_score_q;
   assign in_play   = in_play_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller with STEP_PERIOD=4, HOLD_STEPS=2,
// WIN_SCORE=2. A behavioural model predicts each step tick; predictions are
// queued when a tick is launched and popped when the tick edge has passed.
module tb_ball_controller;

   localparam int unsigned STEP = 4;
   localparam int unsigned HOLD = 2;
   localparam int unsigned WIN  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] p1_y;
   logic [9:0] p2_y;
   logic       bat_size;
   logic       serve;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       p1_point;
   logic       p2_point;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic       in_play;
   logic       game_over;

   always #5 clk = ~clk;

   ball_controller #(
      .STEP_PERIOD (STEP),
      .HOLD_STEPS  (HOLD),
      .WIN_SCORE   (WIN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .p1_y      (p1_y),
      .p2_y      (p2_y),
      .bat_size  (bat_size),
      .serve     (serve),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .p1_point  (p1_point),
      .p2_point  (p2_point),
      .p1_score  (p1_score),
      .p2_score  (p2_score),
      .in_play   (in_play),
      .game_over (game_over)
   );

   typedef struct {
      int   x;
      int   y;
      logic p1pt;
      logic p2pt;
      int   s1;
      int   s2;
      logic play;
      logic over;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // model: 0 idle, 1 play, 2 scored, 3 over
   int mx, my, ms1, ms2, mstate, mhold;
   bit mdx, mdy;
   int phase;   // clock edges already spent since the last tick edge

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic bit hits(input int by, input int py, input bit small_bat);
      int d;
      d = (by > py) ? by - py : py - by;
      return d <= (small_bat ? 44 : 54);
   endfunction

   function automatic int far_from(input int y);
      return (y < 240) ? y + 200 : y - 200;
   endfunction

   task automatic model_reset();
      mx = 320; my = 240; mdx = 1; mdy = 1;
      ms1 = 0; ms2 = 0; mstate = 0; mhold = 0; phase = 0;
   endtask

   task automatic model_tick();
      exp_t e;
      int   oy;
      bit   h1, h2;
      e.p1pt = 1'b0;
      e.p2pt = 1'b0;
      if (mstate == 1) begin
         if (!mdx && mx == 4) begin
            ms2 = (ms2 == 15) ? 15 : ms2 + 1;
            mdx = 0; mstate = 2; mhold = 0; e.p2pt = 1'b1;
         end else if (mdx && mx == 635) begin
            ms1 = (ms1 == 15) ? 15 : ms1 + 1;
            mdx = 1; mstate = 2; mhold = 0; e.p1pt = 1'b1;
         end else begin
            oy = my;
            h1 = hits(oy, int'(p1_y), bat_size);
            h2 = hits(oy, int'(p2_y), bat_size);
            if (!mdy && my == 4) mdy = 1;
            else if (mdy && my == 475) mdy = 0;
            my = mdy ? my + 1 : my - 1;
            if (!mdx && mx == 32 && h1) mdx = 1;
            else if (mdx && mx == 607 && h2) mdx = 0;
            mx = mdx ? mx + 1 : mx - 1;
         end
      end else if (mstate == 2) begin
         mhold++;
         if (mhold == HOLD) begin
            if (ms1 == WIN || ms2 == WIN) mstate = 3;
            else begin
               mstate = 0; mx = 320; my = 240;
            end
         end
      end
      e.x = mx; e.y = my; e.s1 = ms1; e.s2 = ms2;
      e.play = (mstate == 1);
      e.over = (mstate == 3);
      sb.push_back(e);
   endtask

   // One step period: the ball must stay put until the tick edge, then match
   // the queued prediction; a point pulse must be gone one edge later.
   task automatic run_tick(input string tag);
      exp_t e;
      int   ox, oy;
      ox = mx; oy = my;
      model_tick();
      repeat (STEP - 1 - phase) @(posedge clk);
      #1;
      check({tag, "_hold_x"}, ball_x, ox);
      check({tag, "_hold_y"}, ball_y, oy);
      check({tag, "_hold_pts"}, {p1_point, p2_point}, 0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (!e.over) begin
         check({tag, "_x"}, ball_x, e.x);
         check({tag, "_y"}, ball_y, e.y);
      end
      check({tag, "_p1_point"}, p1_point, e.p1pt);
      check({tag, "_p2_point"}, p2_point, e.p2pt);
      check({tag, "_p1_score"}, p1_score, e.s1);
      check({tag, "_p2_score"}, p2_score, e.s2);
      check({tag, "_in_play"}, in_play, e.play);
      check({tag, "_game_over"}, game_over, e.over);
      phase = 0;
      if (e.p1pt || e.p2pt) begin
         @(posedge clk);
         #1;
         check({tag, "_pulse_clear"}, {p1_point, p2_point}, 0);
         phase = 1;
      end
   endtask

   task automatic play_until(input int tx, input bit tdx, input bit hit1, input bit hit2,
                             input string tag);
      bit arrived;
      arrived = 0;
      for (int n = 0; n < 2000; n++) begin
         if ((mx == tx && mdx == tdx) || mstate != 1) begin
            arrived = (mx == tx && mdx == tdx);
            break;
         end
         p1_y = 10'(hit1 ? my : far_from(my));
         p2_y = 10'(hit2 ? my : far_from(my));
         run_tick(tag);
      end
      if (!arrived) begin
         checks++;
         errors++;
         $error("FAIL %s_arrive: model at x=%0d dx=%0d required x=%0d dx=%0d", tag, mx, mdx, tx, tdx);
      end
   endtask

   task automatic do_serve(input string tag);
      serve = 1'b1;
      @(posedge clk);
      #1;
      serve = 1'b0;
      if (mstate == 0) mstate = 1;
      phase = 0;
      check({tag, "_in_play"}, in_play, (mstate == 1));
      check({tag, "_x"}, ball_x, 320);
      check({tag, "_y"}, ball_y, 240);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_x"}, ball_x, 320);
      check({tag, "_y"}, ball_y, 240);
      check({tag, "_p1_point"}, p1_point, 0);
      check({tag, "_p2_point"}, p2_point, 0);
      check({tag, "_p1_score"}, p1_score, 0);
      check({tag, "_p2_score"}, p2_score, 0);
      check({tag, "_in_play"}, in_play, 0);
      check({tag, "_game_over"}, game_over, 0);
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; serve = 1'b0; bat_size = 1'b0; p1_y = 10'd240; p2_y = 10'd240;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_values("reset");

      // idle without serve: nothing moves
      repeat (6) @(posedge clk);
      #1;
      check("idle_in_play", in_play, 0);
      check("idle_x", ball_x, 320);

      // first move 4 cycles after leaving IDLE, to (321,241)
      do_serve("serve1");
      run_tick("first_step");

      // travel right through the bottom-wall bounce to the right paddle
      play_until(607, 1, 1, 1, "to_right");
      bat_size = 1'b0;
      p2_y = 10'(my - 54);           // |diff| = 54: just a hit
      run_tick("right_hit_edge");

      // back left through the top-wall bounce; small bat, |diff| = 44
      play_until(32, 0, 1, 1, "to_left");
      bat_size = 1'b1;
      p1_y = 10'(my + 44);
      run_tick("left_hit_edge");

      // corner: place ball at (32,4) heading up-left, paddle centred on it
      force dut.ball_x_d = 10'd32;
      force dut.ball_y_d = 10'd4;
      force dut.dx_d = 1'b0;
      force dut.dy_d = 1'b0;
      bat_size = 1'b0;
      p1_y = 10'd4;
      @(posedge clk);
      #1;
      release dut.ball_x_d;
      release dut.ball_y_d;
      release dut.dx_d;
      release dut.dy_d;
      mx = 32; my = 4; mdx = 0; mdy = 0;
      phase = 1;
      run_tick("corner");

      // right paddle just misses (|diff| = 55), ball runs on to x=635
      play_until(607, 1, 1, 1, "to_right2");
      p2_y = 10'(my + 55);
      run_tick("right_miss_edge");
      play_until(635, 1, 1, 1, "to_right_wall");
      run_tick("p1_scores");
      run_tick("hold1");
      run_tick("hold2");

      // next serve heads toward p2
      do_serve("serve2");
      run_tick("serve2_step");

      // p2 scores twice: WIN_SCORE=2 ends the game
      play_until(607, 1, 1, 1, "to_right3");
      play_until(32, 0, 1, 1, "to_left3");
      play_until(4, 0, 0, 1, "to_left_wall");
      run_tick("p2_scores1");
      run_tick("hold3");
      run_tick("hold4");
      do_serve("serve3");
      play_until(4, 0, 0, 1, "to_left_wall2");
      run_tick("p2_scores2");
      run_tick("hold5");
      run_tick("hold6");

      // serve ignored once the game is over
      serve = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      serve = 1'b0;
      check("over_in_play", in_play, 0);
      check("over_game_over", game_over, 1);
      check("over_p1_score", p1_score, 1);
      check("over_p2_score", p2_score, 2);

      // reset from OVER restores directions: first move is (321,241)
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_values("reset_over");
      do_serve("serve4");
      run_tick("post_reset1");
      run_tick("post_reset2");
      run_tick("post_reset3");

      // reset mid-period during PLAY
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("reset_play");
      rst = 1'b0;
      do_serve("serve5");
      run_tick("post_reset4");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
